// File: rtl/video_dot_capture_pkg.sv
// Shared constants and helpers for the video dot capture path.
package video_dot_capture_pkg;

    localparam int unsigned VIDEO_BYTE_BITS = 8;

    // Left-justify the n most recent dots of a partial byte, zero-padded on the right.
    function automatic logic [VIDEO_BYTE_BITS-1:0] flush_byte(
        input logic [VIDEO_BYTE_BITS-1:0] sr,
        input logic [2:0]                 n
    );
        logic [3:0] shamt;
        shamt = 4'd8 - {1'b0, n};
        return sr << shamt;
    endfunction

endpackage

// File: rtl/video_cap_fifo.sv
// Synchronous first-word-fall-through FIFO; pushes while full are ignored unless a pop
// happens in the same cycle.
module video_cap_fifo #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WIDTH      = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0] PtrOne = 1;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[PtrW-1:0]];

    always_comb begin
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PtrW-1:0]] = data_i;
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/video_dot_capture.sv
// Deserialises the serial video dot stream into address-tagged bytes and queues them
// for the capture framebuffer write port.
module video_dot_capture
    import video_dot_capture_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  sys_clock_i,
    input  logic                  sys_reset_i,
    input  logic                  pixel_clk_en,
    input  logic                  video_i,
    input  logic                  display_en_i,
    input  logic                  h_sync_i,
    input  logic                  v_sync_i,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [7:0]            wr_data_o,
    output logic                  wr_valid_o,
    input  logic                  wr_ready_i,
    output logic                  frame_done_o,
    output logic                  overrun_o
);

    localparam int unsigned EntryW = ADDR_WIDTH + VIDEO_BYTE_BITS;
    localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;

    logic [VIDEO_BYTE_BITS-1:0] sr_q, sr_d;
    logic [2:0]                 bit_cnt_q, bit_cnt_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic                       hs_q, hs_d, vs_q, vs_d;
    logic                       frame_done_q, frame_done_d;
    logic                       overrun_q, overrun_d;

    logic                       sample, byte_done, hs_rise, vs_rise, flush;
    logic                       push, pop, fifo_full, fifo_empty;
    logic [VIDEO_BYTE_BITS-1:0] push_data;
    logic [EntryW-1:0]          fifo_dout;

    always_comb begin
        sample    = pixel_clk_en & display_en_i;
        byte_done = sample && (bit_cnt_q == 3'd7);
        hs_rise   = h_sync_i & ~hs_q;
        vs_rise   = v_sync_i & ~vs_q;
        // A completing byte takes priority; the flush would otherwise emit an empty entry.
        flush     = hs_rise && (bit_cnt_q != 3'd0) && !byte_done;
        push      = byte_done | flush;
        push_data = byte_done ? {sr_q[6:0], video_i} : flush_byte(sr_q, bit_cnt_q);
        pop       = ~fifo_empty & wr_ready_i;

        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        addr_d       = addr_q;
        hs_d         = h_sync_i;
        vs_d         = v_sync_i;
        frame_done_d = vs_rise;
        overrun_d    = overrun_q | (push & fifo_full & ~pop);

        if (sample) begin
            sr_d      = {sr_q[6:0], video_i};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (flush) begin
            bit_cnt_d = 3'd0;
        end
        // Dropped entries still consume an address so later bytes land correctly.
        if (push) begin
            addr_d = addr_q + AddrOne;
        end
        if (vs_rise) begin
            addr_d    = '0;
            bit_cnt_d = 3'd0;
        end
    end

    always_ff @(posedge sys_clock_i) begin
        if (sys_reset_i) begin
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            addr_q       <= '0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            addr_q       <= addr_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    video_cap_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (EntryW)
    ) u_fifo (
        .clk_i   (sys_clock_i),
        .rst_i   (sys_reset_i),
        .push_i  (push),
        .data_i  ({addr_q, push_data}),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign wr_addr_o    = fifo_dout[EntryW-1:VIDEO_BYTE_BITS];
    assign wr_data_o    = fifo_dout[VIDEO_BYTE_BITS-1:0];
    assign wr_valid_o   = ~fifo_empty;
    assign frame_done_o = frame_done_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_video_dot_capture.sv
// Directed bench for video_dot_capture: a default instance plus a 4-bit-address instance
// for the address wrap scenario.
module tb_video_dot_capture;

    logic        sys_clock_i = 1'b0;
    logic        sys_reset_i = 1'b0;
    logic        pixel_clk_en = 1'b0;
    logic        video_i = 1'b0;
    logic        display_en_i = 1'b1;
    logic        h_sync_i = 1'b0;
    logic        v_sync_i = 1'b0;
    logic        wr_ready_i = 1'b1;
    logic [10:0] wr_addr_o;
    logic [7:0]  wr_data_o;
    logic        wr_valid_o, frame_done_o, overrun_o;
    logic [3:0]  wr_addr4;
    logic [7:0]  wr_data4;
    logic        wr_valid4, frame_done4, overrun4;

    int checks = 0;
    int errors = 0;
    logic [18:0] cap_q[$];
    logic [11:0] cap4_q[$];

    always #5 sys_clock_i = ~sys_clock_i;

    video_dot_capture u_dut (
        .sys_clock_i  (sys_clock_i),
        .sys_reset_i  (sys_reset_i),
        .pixel_clk_en (pixel_clk_en),
        .video_i      (video_i),
        .display_en_i (display_en_i),
        .h_sync_i     (h_sync_i),
        .v_sync_i     (v_sync_i),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .wr_valid_o   (wr_valid_o),
        .wr_ready_i   (wr_ready_i),
        .frame_done_o (frame_done_o),
        .overrun_o    (overrun_o)
    );

    video_dot_capture #(
        .ADDR_WIDTH (4)
    ) u_dut4 (
        .sys_clock_i  (sys_clock_i),
        .sys_reset_i  (sys_reset_i),
        .pixel_clk_en (pixel_clk_en),
        .video_i      (video_i),
        .display_en_i (display_en_i),
        .h_sync_i     (h_sync_i),
        .v_sync_i     (v_sync_i),
        .wr_addr_o    (wr_addr4),
        .wr_data_o    (wr_data4),
        .wr_valid_o   (wr_valid4),
        .wr_ready_i   (wr_ready_i),
        .frame_done_o (frame_done4),
        .overrun_o    (overrun4)
    );

    // Record every accepted write, sampled mid-cycle.
    always @(negedge sys_clock_i) begin
        if (wr_valid_o && wr_ready_i) cap_q.push_back({wr_addr_o, wr_data_o});
        if (wr_valid4 && wr_ready_i) cap4_q.push_back({wr_addr4, wr_data4});
    end

    function automatic logic [18:0] cap_at(input int i);
        if (i < cap_q.size()) return cap_q[i];
        return 'x;
    endfunction

    function automatic logic [11:0] cap4_at(input int i);
        if (i < cap4_q.size()) return cap4_q[i];
        return 'x;
    endfunction

    task automatic step(input logic en, input logic v, input logic hs, input logic vs);
        pixel_clk_en = en;
        video_i      = v;
        h_sync_i     = hs;
        v_sync_i     = vs;
        @(posedge sys_clock_i);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) step(1'b1, b[i], 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        sys_reset_i  = 1'b1;
        pixel_clk_en = 1'b0;
        @(posedge sys_clock_i);
        #1;
        sys_reset_i = 1'b0;
        cap_q.delete();
        cap4_q.delete();
    endtask

    task automatic test_reset();
        h_sync_i = 1'b1;
        v_sync_i = 1'b1;
        do_reset();
        checks++;
        if (wr_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", wr_valid_o);
        end
        checks++;
        if ({wr_addr_o, wr_data_o} !== 19'h0) begin
            errors++; $display("FAIL reset_entry: got %h expected 00000", {wr_addr_o, wr_data_o});
        end
        checks++;
        if ({frame_done_o, overrun_o} !== 2'b00) begin
            errors++; $display("FAIL reset_flags: got %b expected 00", {frame_done_o, overrun_o});
        end
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (frame_done_o !== 1'b0) begin
            errors++; $display("FAIL reset_held_vsync: got %b expected 0", frame_done_o);
        end
        idle(2);
    endtask

    task automatic test_basic_byte();
        logic [7:0] dots;
        dots = 8'b1011_0010;
        wr_ready_i = 1'b1;
        do_reset();
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, dots[i], 1'b0, 1'b0);
            if (i != 0) idle(1);
        end
        checks++;
        if ({wr_valid_o, wr_addr_o, wr_data_o} !== {1'b1, 11'h000, 8'hB2}) begin
            errors++;
            $display("FAIL basic_head: got %b/%h/%h expected 1/000/b2",
                     wr_valid_o, wr_addr_o, wr_data_o);
        end
        idle(1);
        checks++;
        if (wr_valid_o !== 1'b0) begin
            errors++; $display("FAIL basic_one_cycle: got %b expected 0", wr_valid_o);
        end
        idle(2);
        checks++;
        if (cap_q.size() != 1) begin
            errors++; $display("FAIL basic_count: got %0d expected 1", cap_q.size());
        end
    endtask

    task automatic test_partial_flush();
        logic [7:0]  last;
        logic [18:0] exp[4];
        last = 8'h3C;
        exp  = '{{11'd0, 8'hAA}, {11'd1, 8'hAA}, {11'd2, 8'hA0}, {11'd3, 8'h3C}};
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, (i % 2 == 0), 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 7; i >= 1; i--) step(1'b1, last[i], 1'b0, 1'b0);
        step(1'b1, last[0], 1'b1, 1'b0);
        idle(5);
        checks++;
        if (cap_q.size() != 4) begin
            errors++; $display("FAIL flush_count: got %0d expected 4", cap_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_at(i) !== exp[i]) begin
                errors++; $display("FAIL flush_entry%0d: got %h expected %h", i, cap_at(i), exp[i]);
            end
        end
    endtask

    task automatic test_overrun();
        wr_ready_i = 1'b0;
        do_reset();
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        checks++;
        if (overrun_o !== 1'b0) begin
            errors++; $display("FAIL overrun_early: got %b expected 0", overrun_o);
        end
        send_byte(8'h05);
        checks++;
        if (overrun_o !== 1'b1) begin
            errors++; $display("FAIL overrun_set: got %b expected 1", overrun_o);
        end
        send_byte(8'h06);
        checks++;
        if ({wr_valid_o, wr_addr_o, wr_data_o} !== {1'b1, 11'd0, 8'h01}) begin
            errors++;
            $display("FAIL overrun_hold: got %b/%h/%h expected 1/000/01",
                     wr_valid_o, wr_addr_o, wr_data_o);
        end
        wr_ready_i = 1'b1;
        idle(8);
        checks++;
        if (cap_q.size() != 4) begin
            errors++; $display("FAIL overrun_drain_count: got %0d expected 4", cap_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_at(i) !== {11'(i), 8'(i + 1)}) begin
                errors++;
                $display("FAIL overrun_drain%0d: got %h expected %h", i, cap_at(i),
                         {11'(i), 8'(i + 1)});
            end
        end
        send_byte(8'h07);
        idle(3);
        checks++;
        if (cap_at(4) !== {11'd6, 8'h07}) begin
            errors++; $display("FAIL overrun_next_addr: got %h expected %h", cap_at(4), {11'd6, 8'h07});
        end
        checks++;
        if (overrun_o !== 1'b1) begin
            errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun_o);
        end
    endtask

    task automatic test_vsync();
        logic [18:0] exp[5];
        exp = '{{11'd0, 8'h11}, {11'd1, 8'h22}, {11'd2, 8'h33}, {11'd3, 8'hC0}, {11'd0, 8'h44}};
        wr_ready_i = 1'b1;
        do_reset();
        checks++;
        if (overrun_o !== 1'b0) begin
            errors++; $display("FAIL vsync_overrun_cleared: got %b expected 0", overrun_o);
        end
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (frame_done_o !== 1'b1) begin
            errors++; $display("FAIL vsync_pulse: got %b expected 1", frame_done_o);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (frame_done_o !== 1'b0) begin
            errors++; $display("FAIL vsync_pulse_width: got %b expected 0", frame_done_o);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_byte(8'h44);
        idle(3);
        checks++;
        if (cap_q.size() != 5) begin
            errors++; $display("FAIL vsync_count: got %0d expected 5", cap_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cap_at(i) !== exp[i]) begin
                errors++; $display("FAIL vsync_entry%0d: got %h expected %h", i, cap_at(i), exp[i]);
            end
        end
    endtask

    task automatic test_wrap_gating();
        logic [7:0] tail;
        tail = 8'b1011_0011;
        wr_ready_i = 1'b1;
        do_reset();
        for (int i = 1; i <= 17; i++) send_byte(8'(i));
        idle(3);
        checks++;
        if (cap4_q.size() != 17) begin
            errors++; $display("FAIL wrap_count: got %0d expected 17", cap4_q.size());
        end
        checks++;
        if (cap4_at(15) !== {4'hF, 8'h10}) begin
            errors++; $display("FAIL wrap_last: got %h expected f10", cap4_at(15));
        end
        checks++;
        if (cap4_at(16) !== {4'h0, 8'h11}) begin
            errors++; $display("FAIL wrap_zero: got %h expected 011", cap4_at(16));
        end
        for (int i = 7; i >= 5; i--) step(1'b1, tail[i], 1'b0, 1'b0);
        display_en_i = 1'b0;
        for (int i = 0; i < 25; i++) step(1'b1, i[0], 1'b0, 1'b0);
        display_en_i = 1'b1;
        for (int i = 0; i < 25; i++) step(1'b0, i[0], 1'b0, 1'b0);
        checks++;
        if (wr_valid_o !== 1'b0 || cap_q.size() != 17) begin
            errors++;
            $display("FAIL gating_quiet: got valid=%b count=%0d expected valid=0 count=17",
                     wr_valid_o, cap_q.size());
        end
        for (int i = 4; i >= 0; i--) step(1'b1, tail[i], 1'b0, 1'b0);
        idle(3);
        checks++;
        if (cap_at(17) !== {11'd17, 8'hB3}) begin
            errors++; $display("FAIL gating_byte: got %h expected %h", cap_at(17), {11'd17, 8'hB3});
        end
        checks++;
        if (cap4_at(17) !== {4'h1, 8'hB3}) begin
            errors++; $display("FAIL gating_byte4: got %h expected 1b3", cap4_at(17));
        end
    endtask

    task automatic test_reset_mid();
        wr_ready_i = 1'b0;
        do_reset();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (wr_valid_o !== 1'b1) begin
            errors++; $display("FAIL midreset_pre: got %b expected 1", wr_valid_o);
        end
        sys_reset_i = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        sys_reset_i = 1'b0;
        checks++;
        if ({wr_valid_o, wr_addr_o, wr_data_o} !== 20'h0) begin
            errors++;
            $display("FAIL midreset_flushed: got %b/%h/%h expected 0/000/00",
                     wr_valid_o, wr_addr_o, wr_data_o);
        end
        wr_ready_i = 1'b1;
        send_byte(8'h5A);
        idle(3);
        checks++;
        if (cap_q.size() != 1 || cap_at(0) !== {11'd0, 8'h5A}) begin
            errors++;
            $display("FAIL midreset_byte: got count=%0d entry=%h expected count=1 entry=%h",
                     cap_q.size(), cap_at(0), {11'd0, 8'h5A});
        end
    endtask

    initial begin
        test_reset();
        test_basic_byte();
        test_partial_flush();
        test_overrun();
        test_vsync();
        test_wrap_gating();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
